// File: rtl/wb_stage_ctrl.sv
// Write-back stage: selects ALU / load / link value, drives one registered
// register-file write port, stalls for late load data and counts retirements.
module wb_stage_ctrl #(
    parameter int                DATA_W      = 32,
    parameter int                REG_AW      = 4,
    parameter logic [REG_AW-1:0] LINK_REG    = {REG_AW{1'b1}},
    parameter int                PC_INC      = 4,
    parameter bit                ZERO_REG_EN = 1'b0,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_iswb,
    input  logic              in_iscall,
    input  logic              in_isld,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              err
);

    localparam logic S_IDLE    = 1'b0;
    localparam logic S_WAIT_LD = 1'b1;

    logic              state;
    logic [REG_AW-1:0] pend_addr_p1;
    logic              pend_we_p1;

    logic [REG_AW-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_we;
    logic              ld_we;

    function automatic logic [DATA_W-1:0] ret_addr(input logic [DATA_W-1:0] pc);
        return pc + DATA_W'(PC_INC);
    endfunction

    function automatic logic wr_allowed(input logic [REG_AW-1:0] addr);
        return !(ZERO_REG_EN && (addr == '0));
    endfunction

    assign in_ready = (state == S_IDLE);

    // Source select for bundles that complete immediately, and the write
    // qualifier remembered for a load (call+load is illegal: no write).
    always_comb begin
        sel_addr = in_iscall ? LINK_REG : in_rd;
        sel_data = in_iscall ? ret_addr(in_pc) : in_alu;
        sel_we   = in_iswb && !(in_iscall && in_isld) && wr_allowed(sel_addr);
        ld_we    = in_iswb && !in_iscall && wr_allowed(in_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pend_addr_p1 <= '0;
            pend_we_p1   <= 1'b0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            retired_cnt  <= '0;
            err          <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld_valid)
                        err <= 1'b1;
                    if (in_valid) begin
                        if (in_isld) begin
                            state        <= S_WAIT_LD;
                            pend_addr_p1 <= in_rd;
                            pend_we_p1   <= ld_we;
                            if (in_iscall)
                                err <= 1'b1;
                        end else begin
                            rf_we       <= sel_we;
                            retired_cnt <= retired_cnt + CNT_W'(1);
                            if (sel_we) begin
                                rf_waddr <= sel_addr;
                                rf_wdata <= sel_data;
                            end
                        end
                    end
                end
                S_WAIT_LD: begin
                    if (ld_valid) begin
                        state       <= S_IDLE;
                        rf_we       <= pend_we_p1;
                        retired_cnt <= retired_cnt + CNT_W'(1);
                        if (pend_we_p1) begin
                            rf_waddr <= pend_addr_p1;
                            rf_wdata <= ld_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Bench for wb_stage_ctrl: directed scenarios plus random bundles, with a
// write scoreboard fed by the driver and drained by an independent monitor.
module tb_wb_stage_ctrl;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_iswb;
    logic              in_iscall;
    logic              in_isld;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_pc;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  retired_cnt;
    logic              err;

    wb_stage_ctrl #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .LINK_REG(4'b1111),
        .PC_INC(4), .ZERO_REG_EN(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_iswb(in_iswb), .in_iscall(in_iscall), .in_isld(in_isld),
        .in_rd(in_rd), .in_alu(in_alu), .in_pc(in_pc),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retired_cnt(retired_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [REG_AW-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned m_cnt  = 0;
    logic        m_err  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                         rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
                chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
            end
        end
    end

    // Issue one bundle (called at a falling edge); for loads, return data
    // after lat cycles. Expected writes come from the stage's rules directly.
    task automatic op(input logic wb, input logic call, input logic ld,
                      input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] alu,
                      input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] ldd,
                      input int lat);
        wr_t  e;
        logic we;
        e.a = (call && !ld) ? 4'd15 : rd;
        e.d = ld ? ldd : (call ? pc + 32'd4 : alu);
        we  = wb && !(call && ld) && (e.a != 4'd0);
        if (call && ld)
            m_err = 1'b1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_iswb   = wb;
        in_iscall = call;
        in_isld   = ld;
        in_rd     = rd;
        in_alu    = alu;
        in_pc     = pc;
        if (!ld) begin
            if (we) exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 1; i < lat; i++) begin
                chk("in_ready_wait", 64'(in_ready), 64'd0);
                @(negedge clk);
            end
            chk("in_ready_wait", 64'(in_ready), 64'd0);
            ld_valid = 1'b1;
            ld_data  = ldd;
            if (we) exp_q.push_back(e);
            @(negedge clk);
            ld_valid = 1'b0;
        end
        m_cnt++;
        chk("retired_cnt", 64'(retired_cnt), 64'(m_cnt));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic stray_ld();
        ld_valid = 1'b1;
        ld_data  = $urandom;
        @(negedge clk);
        ld_valid = 1'b0;
        m_err    = 1'b1;
        chk("err_stray", 64'(err), 64'(m_err));
        chk("retired_cnt_stray", 64'(retired_cnt), 64'(m_cnt));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_iswb = 1'b0; in_iscall = 1'b0;
        in_isld = 1'b0; in_rd = '0; in_alu = '0; in_pc = '0;
        ld_valid = 1'b0; ld_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_retired_cnt", 64'(retired_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op(1, 0, 0, 4'd3, 32'h0000_1234, 32'h0, 32'h0, 0);
        op(1, 1, 0, 4'd2, 32'h5555_5555, 32'hFFFF_FFFC, 32'h0, 0);
        op(0, 0, 0, 4'd4, 32'h7777_7777, 32'h0, 32'h0, 0);
        op(1, 0, 1, 4'd5, 32'h0, 32'h0, 32'hDEAD_BEEF, 3);
        op(1, 0, 0, 4'd6, 32'hA5A5_0001, 32'h0, 32'h0, 0);
        op(1, 0, 1, 4'd8, 32'h0, 32'h0, 32'h0BAD_F00D, 1);
        for (int i = 0; i < 4; i++)
            op(1, 0, 0, 4'(i + 9), 32'h1000 + 32'(i), 32'h0, 32'h0, 0);
        op(1, 0, 0, 4'd0, 32'hCAFE_0000, 32'h0, 32'h0, 0);
        op(0, 0, 1, 4'd7, 32'h0, 32'h0, 32'h1111_2222, 2);

        for (int n = 0; n < 250; n++) begin
            logic ld, call;
            ld   = ($urandom_range(0, 2) == 0);
            call = !ld && ($urandom_range(0, 3) == 0);
            op(($urandom_range(0, 4) != 0), call, ld, 4'($urandom), $urandom,
               $urandom, $urandom, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0)
                @(negedge clk);
        end

        stray_ld();
        op(1, 1, 1, 4'd6, 32'h0, 32'h0, 32'h3333_4444, 2);
        op(1, 0, 0, 4'd12, 32'h0000_ABCD, 32'h0, 32'h0, 0);

        // Reset in the middle of a load wait.
        in_valid = 1'b1; in_iswb = 1'b1; in_iscall = 1'b0; in_isld = 1'b1; in_rd = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_wait", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_rf_we", 64'(rf_we), 64'd0);
        chk("midrst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("midrst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("midrst_retired_cnt", 64'(retired_cnt), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        m_cnt = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray_ld();
        op(1, 0, 0, 4'd0, 32'h0000_0F0F, 32'h0, 32'h0, 0);
        op(1, 0, 0, 4'd1, 32'h0000_0F0F, 32'h0, 32'h0, 0);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
